mux7seg_capture: RTL and testbench
==================================

Name: mux7seg_capture

Overview:
- Receive end of the time-multiplexed two-digit seven-segment GPIO bus (7 segment lines plus 2 select lines, one digit shown per select phase).
- Synchronises, debounces and decodes the bus back to two hex digits, with valid, error and timeout status.
- Sits on the bench/FPGA side of the board that monitors the external display. Used for loopback checking of the display driver.

Parameters:
STABLE_CYCLES, 16, consecutive identical synchronised samples required before a digit is accepted (>=2)
TIMEOUT_CYCLES, 1048576, cycles without an accepted update before that digit's valid clears
TMO_W, 21, width of each timeout counter (must hold TIMEOUT_CYCLES)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-low
seg_in  in  7  segment lines, bit0=a .. bit6=g, active-high = lit
sel_in  in  2  digit select: 2'b01 = digit1 (upper), 2'b10 = digit0 (lower); 00/11 = idle
digit0  out  4  decoded lower digit
digit1  out  4  decoded upper digit
digit_valid  out  2  bit n = digitn holds a live value
update  out  1  one-cycle pulse when digit0 or digit1 register changes value
code_err  out  1  one-cycle pulse on an accepted sample with an undecodable pattern
err_cnt  out  8  saturating count of code_err pulses
bus_timeout  out  1  high while digit_valid == 2'b00 after both have been valid at least once

Behaviour:
- Reset (reset==0 at a CLOCK_50 edge): digit0=digit1=0, digit_valid=00, update=0, code_err=0, err_cnt=0, bus_timeout=0. Sync flops load seg=0, sel=00. Stability counter, accepted flag, timeout counters and seen-both flag are cleared. Reset mid-frame discards any partial sample.
- Input path: 2-flop synchroniser on {sel_in, seg_in} as one 9-bit word. Stage-2 output S is compared to its previous value P.
- Stability: if S!=P, stab_cnt=0 and acc=0. Otherwise stab_cnt increments, saturating at STABLE_CYCLES-1.
- Accept: occurs when stab_cnt==STABLE_CYCLES-1, S==P and acc==0. acc then sets, so there is one accept per stable episode.
- Latency: a pattern applied at the pins before edge t is accepted at edge t+1+STABLE_CYCLES. The outputs update on that edge.
- Accept with sel 00 or 11: ignored, with no output change.
- Decode table (seg hex -> digit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
- Accept with valid sel and a pattern in the table:
  - Write the selected digit and set its valid bit.
  - Reload that digit's timeout counter to 0.
  - update=1 for one cycle only if the new value differs from the stored value or the valid bit was 0.
- Accept with valid sel and a pattern not in the table:
  - code_err=1 for one cycle; err_cnt += 1, saturating at 255.
  - Digit register and valid bit are unchanged, and the timeout counter is not reloaded.
- Timeout: each valid digit's counter increments every cycle. When it reaches TIMEOUT_CYCLES-1, the valid bit clears on the next edge; the digit value is retained.
- If an accept and a timeout expiry for the same digit fall on the same edge, the accept wins: valid stays 1 and the counter resets.
- bus_timeout: seen_both sets the first time digit_valid==11. bus_timeout = seen_both & (digit_valid==00), registered. It clears on the next valid accept.
- FSM per digit: EMPTY -> (accept ok) -> LIVE. LIVE -> (timeout) -> STALE. STALE -> (accept ok) -> LIVE. Reset -> EMPTY. digit_valid is 1 only in LIVE.

Optional Feature:
- Macro: MUXCAP_ACTIVE_LOW_EN.
- Defined: seg_in and sel_in are active-low (common-anode boards). Both are inverted before the synchroniser. The reset value of the sync flops is then the inverted idle word, so the internal view is still seg=0, sel=00.
- Undefined: the polarities are as listed under Ports.
- All decode, timing and status behaviour is identical in both builds.

Test Plan:
- STABLE_CYCLES=4: hold sel=10, seg=7'h4F, 10 cycles after reset -> digit0=3, digit_valid=01, update pulses once, 5 edges after the pins settle.
- Hold sel=01, seg=7'h6D -> digit1=5, valid=11. Reapply the same pattern after an idle sel=00 gap -> no update pulse.
- Glitch: seg=7'h06 for 3 cycles then 7'h5B held, STABLE_CYCLES=4 -> digit never 1, digit ends 2, single update.
- Invalid pattern seg=7'h00 with sel=10, repeated 300 episodes -> 300 code_err pulses, err_cnt=255, digit0 unchanged.
- TIMEOUT_CYCLES=64, both digits live then sel=00 -> valid clears on cycle 64 per digit, bus_timeout=1. Accept on the expiry edge -> valid held.
- Assert reset for one cycle during a stable sample -> all outputs zero next cycle, sample must re-qualify for the full STABLE_CYCLES.

Source files
------------

// File: rtl/mux7seg_capture_if.sv
// Seven-segment display bus: 7 segment lines plus 2 digit-select lines.
// The display driver is the master; the capture block is the slave.
interface mux7seg_capture_if;
  logic [6:0] seg_in;
  logic [1:0] sel_in;

  modport master (output seg_in, output sel_in);
  modport slave  (input  seg_in, input  sel_in);
endinterface

// File: rtl/mux7seg_capture.sv
// mux7seg_capture: receive end of a two-digit multiplexed seven-segment bus.
// Synchronises the 9-bit {sel, seg} word, waits for STABLE_CYCLES identical
// samples, decodes the hex glyph into digit0/digit1 and reports update,
// code_err, err_cnt, per-digit validity with timeout, and bus_timeout.
//
// Build option: define MUXCAP_ACTIVE_LOW_EN for common-anode boards where
// seg_in/sel_in are active-low; the pins are inverted ahead of the
// synchroniser so everything downstream sees active-high values.
//
// Per-digit state:
//   state | meaning
//   EMPTY | no glyph accepted since reset, digit not valid
//   LIVE  | glyph accepted recently, digit valid, timeout counter running
//   STALE | no accept for TIMEOUT_CYCLES, digit value kept but not valid
module mux7seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TMO_W          = 21
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  mux7seg_capture_if.slave  bus,
  output logic [3:0]        digit0,
  output logic [3:0]        digit1,
  output logic [1:0]        digit_valid,
  output logic              update,
  output logic              code_err,
  output logic [7:0]        err_cnt,
  output logic              bus_timeout
);

  localparam int                STAB_W   = $clog2(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    STALE = 2'd2
  } dstate_t;

  logic [8:0]        raw_word;
  logic [8:0]        sync1;
  logic [8:0]        sync2;
  logic [8:0]        prev;
  logic [STAB_W-1:0] stab_cnt;
  logic [STAB_W-1:0] stab_nxt;
  logic              acc;
  logic              same;
  logic              accept;
  logic [4:0]        dec;
  logic              code_ok;
  logic              sel_ok;
  logic [1:0]        take;
  logic              bad;
  logic [1:0]        expire;
  logic [1:0]        valid_nxt;
  logic              seen_both;

  dstate_t           state   [2];
  logic [TMO_W-1:0]  tmo_cnt [2];
  logic [3:0]        digit_q [2];

`ifdef MUXCAP_ACTIVE_LOW_EN
  assign raw_word = ~{bus.sel_in, bus.seg_in};
`else
  assign raw_word = {bus.sel_in, bus.seg_in};
`endif

  // Glyph decode; bit 4 flags a pattern found in the hex table.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign same = (sync2 == prev);

  // Next stability count; accept fires on the edge the count reaches its
  // ceiling so a pattern set before edge t lands at edge t+1+STABLE_CYCLES.
  always_comb begin
    stab_nxt = '0;
    if (same) begin
      stab_nxt = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 1'b1;
    end
  end

  assign accept  = same && (stab_nxt == STAB_MAX) && !acc;
  assign dec     = decode_seg(sync2[6:0]);
  assign code_ok = dec[4];
  assign sel_ok  = (sync2[8:7] == 2'b10) || (sync2[8:7] == 2'b01);
  assign take[0] = accept && (sync2[8:7] == 2'b10) && code_ok;
  assign take[1] = accept && (sync2[8:7] == 2'b01) && code_ok;
  assign bad     = accept && sel_ok && !code_ok;

  assign expire[0] = (state[0] == LIVE) && (tmo_cnt[0] == TMO_MAX);
  assign expire[1] = (state[1] == LIVE) && (tmo_cnt[1] == TMO_MAX);

  // An accept on the expiry edge keeps the digit valid.
  assign valid_nxt = take | (digit_valid & ~expire);

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];

  // Input synchroniser, previous-sample register and stability tracking.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
      acc      <= 1'b0;
    end else begin
      sync1    <= raw_word;
      sync2    <= sync1;
      prev     <= sync2;
      stab_cnt <= stab_nxt;
      if (!same) begin
        acc <= 1'b0;
      end else if (accept) begin
        acc <= 1'b1;
      end
    end
  end

  // Per-digit EMPTY/LIVE/STALE machines with registered status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        state[n]   <= EMPTY;
        tmo_cnt[n] <= '0;
        digit_q[n] <= 4'h0;
      end
      digit_valid <= 2'b00;
      update      <= 1'b0;
      code_err    <= 1'b0;
      err_cnt     <= 8'h00;
      seen_both   <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        case (state[n])
          EMPTY, STALE: begin
            if (take[n]) begin
              state[n]   <= LIVE;
              tmo_cnt[n] <= '0;
            end
          end
          LIVE: begin
            if (take[n]) begin
              tmo_cnt[n] <= '0;
            end else if (expire[n]) begin
              state[n]   <= STALE;
              tmo_cnt[n] <= '0;
            end else begin
              tmo_cnt[n] <= tmo_cnt[n] + 1'b1;
            end
          end
          default: begin
            state[n]   <= EMPTY;
            tmo_cnt[n] <= '0;
          end
        endcase
        if (take[n]) begin
          digit_q[n] <= dec[3:0];
        end
      end
      digit_valid <= valid_nxt;
      update      <= (|(take & ~digit_valid))
                     || (take[0] && (dec[3:0] != digit_q[0]))
                     || (take[1] && (dec[3:0] != digit_q[1]));
      code_err    <= bad;
      if (bad && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
      seen_both   <= seen_both | (&valid_nxt);
      bus_timeout <= seen_both & (valid_nxt == 2'b00);
    end
  end

endmodule

// File: tb/tb_mux7seg_capture.sv
// Bench for mux7seg_capture with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
// A per-edge reference model (pin run lengths, accept times, age since
// accept) checks every cycle; a vector table and short hand sequences check
// latency, re-qualification after reset, timeout and error saturation.
module tb_mux7seg_capture;
  localparam int N  = 4;
  localparam int T  = 64;
  localparam int TW = 7;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [1:0] sel_v;
  logic [6:0] seg_v;
  logic [3:0] digit0, digit1;
  logic [1:0] digit_valid;
  logic       update, code_err, bus_timeout;
  logic [7:0] err_cnt;

  always #10 CLOCK_50 = ~CLOCK_50;

  mux7seg_capture_if bus_if ();

`ifdef MUXCAP_ACTIVE_LOW_EN
  assign bus_if.sel_in = ~sel_v;
  assign bus_if.seg_in = ~seg_v;
`else
  assign bus_if.sel_in = sel_v;
  assign bus_if.seg_in = seg_v;
`endif

  mux7seg_capture #(.STABLE_CYCLES(N), .TIMEOUT_CYCLES(T), .TMO_W(TW)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .bus         (bus_if),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit_valid (digit_valid),
    .update      (update),
    .code_err    (code_err),
    .err_cnt     (err_cnt),
    .bus_timeout (bus_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         edge_no;
    logic [8:0] w;
  } pend_t;

  logic [6:0] codes [16];
  pend_t      pend [$];
  int         edge_no;
  logic [8:0] last_w;
  int         run;
  logic [3:0] m_val [2];
  int         m_acc [2];
  bit         m_seen, m_upd, m_cerr, m_bto;
  int         m_err;

  function automatic bit m_valid(input int idx, input int e);
    return (e - m_acc[idx]) < T;
  endfunction

  task automatic m_apply(input logic [8:0] w);
    int idx;
    int d;
    idx = -1;
    d   = -1;
    if (w[8:7] == 2'b10) idx = 0;
    else if (w[8:7] == 2'b01) idx = 1;
    if (idx >= 0) begin
      for (int k = 0; k < 16; k++) if (codes[k] == w[6:0]) d = k;
      if (d >= 0) begin
        if (!m_valid(idx, edge_no - 1) || (m_val[idx] != 4'(d))) m_upd = 1;
        m_val[idx] = 4'(d);
        m_acc[idx] = edge_no;
      end else begin
        m_cerr = 1;
        if (m_err < 255) m_err++;
      end
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic [8:0] w);
    edge_no++;
    m_upd  = 0;
    m_cerr = 0;
    if (!rst_v) begin
      m_val[0] = 4'h0;
      m_val[1] = 4'h0;
      m_acc[0] = -1000000;
      m_acc[1] = -1000000;
      m_seen   = 0;
      m_err    = 0;
      m_bto    = 0;
      pend.delete();
      last_w   = 9'h000;
      run      = N + 1;
    end else begin
      if ((pend.size() > 0) && (pend[0].edge_no == edge_no)) begin
        m_apply(pend[0].w);
        void'(pend.pop_front());
      end
      if (w == last_w) begin
        if (run < N + 1) run++;
      end else begin
        last_w = w;
        run    = 1;
      end
      if (run == N) pend.push_back('{edge_no + 2, w});
      if (m_valid(0, edge_no) && m_valid(1, edge_no)) m_seen = 1;
      m_bto = m_seen && !m_valid(0, edge_no) && !m_valid(1, edge_no);
    end
  endtask

  task automatic step();
    logic [20:0] got;
    logic [20:0] exp;
    @(posedge CLOCK_50);
    model_edge(reset, {sel_v, seg_v});
    #1;
    got = {digit0, digit1, digit_valid, update, code_err, err_cnt, bus_timeout};
    exp = {m_val[0], m_val[1], m_valid(1, edge_no), m_valid(0, edge_no),
           m_upd, m_cerr, 8'(m_err), m_bto};
    check("model", {11'h0, got}, {11'h0, exp});
  endtask

  task automatic drive(input logic [1:0] s, input logic [6:0] g);
    sel_v = s;
    seg_v = g;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] sel;
    logic [6:0] seg;
    int         hold;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] v;
    int         upd;
    int         cerr;
    int         err;
  } vec_t;

  vec_t vt [10];

  initial begin
    int nu, nc, got_upd, cnt;

    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    vt[0] = '{2'b10, 7'h4F, 8, 4'h3, 4'h0, 2'b01, 1, 0, 0};
    vt[1] = '{2'b01, 7'h6D, 8, 4'h3, 4'h5, 2'b11, 1, 0, 0};
    vt[2] = '{2'b00, 7'h00, 8, 4'h3, 4'h5, 2'b11, 0, 0, 0};
    vt[3] = '{2'b01, 7'h6D, 8, 4'h3, 4'h5, 2'b11, 0, 0, 0};
    vt[4] = '{2'b10, 7'h06, 3, 4'h3, 4'h5, 2'b11, 0, 0, 0};
    vt[5] = '{2'b10, 7'h5B, 8, 4'h2, 4'h5, 2'b11, 1, 0, 0};
    vt[6] = '{2'b11, 7'h7F, 8, 4'h2, 4'h5, 2'b11, 0, 0, 0};
    vt[7] = '{2'b10, 7'h00, 8, 4'h2, 4'h5, 2'b11, 0, 1, 1};
    vt[8] = '{2'b01, 7'h77, 8, 4'h2, 4'hA, 2'b11, 1, 0, 1};
    vt[9] = '{2'b10, 7'h7C, 8, 4'hB, 4'hA, 2'b11, 1, 0, 1};

    edge_no = 0;
    reset   = 1'b0;
    drive(2'b00, 7'h00);
    step();
    step();
    check("reset_state",
          {11'h0, digit0, digit1, digit_valid, update, code_err, err_cnt, bus_timeout}, 32'h0);
    reset = 1'b1;

    // table: each record holds one pattern, then checks final state
    for (int i = 0; i < 10; i++) begin
      nu = 0;
      nc = 0;
      drive(vt[i].sel, vt[i].seg);
      repeat (vt[i].hold) begin
        step();
        nu += int'(update);
        nc += int'(code_err);
      end
      check($sformatf("vec%0d_digit0", i), 32'(digit0), 32'(vt[i].d0));
      check($sformatf("vec%0d_digit1", i), 32'(digit1), 32'(vt[i].d1));
      check($sformatf("vec%0d_valid", i), 32'(digit_valid), 32'(vt[i].v));
      check($sformatf("vec%0d_updates", i), 32'(nu), 32'(vt[i].upd));
      check($sformatf("vec%0d_code_errs", i), 32'(nc), 32'(vt[i].cerr));
      check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vt[i].err));
    end

    // latency: pattern set before edge 1 is accepted at edge 1+1+N = 6
    drive(2'b00, 7'h00);
    repeat (4) step();
    drive(2'b10, 7'h66);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("latency_edge%0d", i), 32'(update), (i == 6) ? 32'h1 : 32'h0);
    end
    check("latency_digit0", 32'(digit0), 32'h4);

    // one-cycle reset during a stable sample, then full re-qualification
    drive(2'b01, 7'h39);
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_mid_outputs",
          {11'h0, digit0, digit1, digit_valid, update, code_err, err_cnt, bus_timeout}, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("requalify_edge%0d", k), 32'(update), (k == 6) ? 32'h1 : 32'h0);
    end
    check("requalify_digit1", 32'(digit1), 32'hC);
    check("requalify_valid", 32'(digit_valid), 32'h2);

    // timeout: digit0 valid for exactly T edges after its accept
    drive(2'b00, 7'h00);
    repeat (2) step();
    drive(2'b10, 7'h4F);
    got_upd = 0;
    for (int i = 0; i < 12 && got_upd == 0; i++) begin
      step();
      if (update === 1'b1) got_upd = 1;
    end
    check("tmo_accept_seen", 32'(got_upd), 32'h1);
    drive(2'b00, 7'h00);
    cnt = 0;
    repeat (T - 1) begin
      step();
      cnt += int'(digit_valid[0]);
    end
    check("tmo_valid_cycles", 32'(cnt), 32'(T - 1));
    step();
    check("tmo_valid_cleared", 32'(digit_valid), 32'h0);
    check("tmo_bus_timeout", 32'(bus_timeout), 32'h1);
    check("tmo_digit0_kept", 32'(digit0), 32'h3);

    // accept landing on the expiry edge keeps the digit valid
    drive(2'b10, 7'h4F);
    got_upd = 0;
    for (int i = 0; i < 12 && got_upd == 0; i++) begin
      step();
      if (update === 1'b1) got_upd = 1;
    end
    check("exp_accept_seen", 32'(got_upd), 32'h1);
    check("exp_bus_timeout_clear", 32'(bus_timeout), 32'h0);
    drive(2'b00, 7'h00);
    repeat (T - 6) step();
    drive(2'b10, 7'h4F);
    repeat (5) step();
    step();
    check("exp_edge_valid", 32'(digit_valid[0]), 32'h1);
    check("exp_edge_no_update", 32'(update), 32'h0);
    repeat (2) step();
    check("exp_after_valid", 32'(digit_valid[0]), 32'h1);

    // 300 undecodable episodes: err_cnt saturates, digit0 untouched
    nc = 0;
    for (int ep = 0; ep < 300; ep++) begin
      drive(2'b10, 7'h00);
      repeat (6) begin
        step();
        nc += int'(code_err);
      end
      drive(2'b00, 7'h00);
      repeat (2) begin
        step();
        nc += int'(code_err);
      end
    end
    check("sat_code_err_pulses", 32'(nc), 32'd300);
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    check("sat_digit0", 32'(digit0), 32'h3);

    // random episodes against the model
    for (int s = 0; s < 300; s++) begin
      reset = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      sel_v = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) seg_v = codes[$urandom_range(0, 15)];
      else seg_v = 7'($urandom);
      repeat ($urandom_range(1, 9)) step();
    end
    reset = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
